// File: rtl/dds_sweep_ctrl_if.sv
// Phase-increment stream between the sweep sequencer and the DDS compiler.
// The master drives tdata/tvalid and the slave returns tready.
interface dds_sweep_ctrl_if #(
    parameter int PHASE_WIDTH = 32
);
    logic [PHASE_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS tuning-word sequencer: streams a carrier increment while idle and steps
// a linear chirp sweep with a per-step dwell (in accepted beats) on request.
module dds_sweep_ctrl #(
    parameter int PHASE_WIDTH = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [PHASE_WIDTH-1:0] idle_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_start_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_step,
    input  logic [COUNT_WIDTH-1:0] cfg_num_steps,
    input  logic [COUNT_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_loop,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] step_idx,
    dds_sweep_ctrl_if.master       m_axis_phase
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                         r_state;
    logic        [PHASE_WIDTH-1:0]  r_tdata;
    logic                           r_tvalid;
    logic                           r_busy;
    logic                           r_done;
    logic        [COUNT_WIDTH-1:0]  r_step_idx;
    logic        [COUNT_WIDTH-1:0]  r_dwell_cnt;
    logic        [PHASE_WIDTH-1:0]  r_start_inc;
    logic signed [PHASE_WIDTH-1:0]  r_step;
    logic        [COUNT_WIDTH-1:0]  r_last_idx;
    logic        [COUNT_WIDTH-1:0]  r_dwell_last;
    logic                           r_loop;

    logic w_beat;
    logic w_dwell_end;
    logic w_last_step;

    // Tuning words wrap modulo 2^PHASE_WIDTH; a negative step sweeps downward.
    function automatic logic [PHASE_WIDTH-1:0] f_wrap_add(
        input logic        [PHASE_WIDTH-1:0] a,
        input logic signed [PHASE_WIDTH-1:0] d
    );
        return a + $unsigned(d);
    endfunction

    assign w_beat      = r_tvalid & m_axis_phase.tready;
    assign w_dwell_end = (r_dwell_cnt == r_dwell_last);
    assign w_last_step = (r_step_idx == r_last_idx);

    assign m_axis_phase.tdata  = r_tdata;
    assign m_axis_phase.tvalid = r_tvalid;
    assign busy                = r_busy;
    assign done                = r_done;
    assign step_idx            = r_step_idx;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= IDLE;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_step_idx   <= '0;
            r_dwell_cnt  <= '0;
            r_start_inc  <= '0;
            r_step       <= '0;
            r_last_idx   <= '0;
            r_dwell_last <= '0;
            r_loop       <= 1'b0;
        end else begin
            r_tvalid <= 1'b1;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tdata     <= idle_inc;
                    r_busy      <= 1'b0;
                    r_step_idx  <= '0;
                    r_dwell_cnt <= '0;
                    if (start && !abort) begin
                        r_start_inc  <= cfg_start_inc;
                        r_step       <= $signed(cfg_step);
                        r_last_idx   <= cfg_num_steps - COUNT_WIDTH'(1);
                        r_dwell_last <= (cfg_dwell == '0) ? '0 : cfg_dwell - COUNT_WIDTH'(1);
                        r_loop       <= cfg_loop;
                        // An empty sweep completes immediately without leaving the carrier.
                        if (cfg_num_steps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= SWEEP;
                            r_tdata <= cfg_start_inc;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        r_state     <= IDLE;
                        r_tdata     <= idle_inc;
                        r_busy      <= 1'b0;
                        r_step_idx  <= '0;
                        r_dwell_cnt <= '0;
                    end else if (w_beat) begin
                        if (!w_dwell_end) begin
                            r_dwell_cnt <= r_dwell_cnt + COUNT_WIDTH'(1);
                        end else begin
                            r_dwell_cnt <= '0;
                            if (!w_last_step) begin
                                r_step_idx <= r_step_idx + COUNT_WIDTH'(1);
                                r_tdata    <= f_wrap_add(r_tdata, r_step);
                            end else if (r_loop) begin
                                r_step_idx <= '0;
                                r_tdata    <= r_start_inc;
                            end else begin
                                r_state    <= IDLE;
                                r_tdata    <= idle_inc;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_step_idx <= '0;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
